regfile_wb_arbiter: RTL and testbench

- Drives the register file write port (write enable, 5-bit address, 32-bit data) from two producers.
- Port A is the in-order pipeline writeback. Port B is long-latency units (mul/div, cache-miss loads) and uses a valid/ready handshake with a DEPTH-entry FIFO.
- Port A has priority. A starvation counter forces B drains.
- Pending-write lookup ports let the hazard unit detect reads of registers not yet written.

---
 rtl/regfile_wb_arbiter_pkg.sv | 26 ++
 rtl/regfile_wb_arbiter_wb_fifo.sv | 80 ++++++++
 rtl/regfile_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register file writeback arbiter.
// Holds write request layout and small address helpers.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_A,
    SEL_B
  } wb_sel_e;

  function automatic logic addr_match(
    input logic [REG_ADDR_W-1:0] q,
    input logic [REG_ADDR_W-1:0] e
  );
    return (q != '0) && (q == e);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Circular buffer holding queued long-latency writebacks.
// Exposes valid entry addresses (invalid slots read as x0).
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  wb_req_t                     push_req,
  input  logic                        pop,
  output wb_req_t                     head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic [DEPTH*REG_ADDR_W-1:0] pend_addrs
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t       mem_q [DEPTH];
  wb_req_t       mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;
  logic [PW-1:0] off;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_req;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Slot is live when its distance from the head is below occupancy
  always_comb begin
    pend_addrs = '0;
    off        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q) begin
        pend_addrs[i*REG_ADDR_W +: REG_ADDR_W] = mem_q[i].addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write port arbiter: pipeline writeback (A)
// over queued long-latency results (B), with starvation relief.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_data,
  output logic                  a_stall,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_data,
  output logic [$clog2(DEPTH):0] b_count,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0]     reg_din,
  input  logic [REG_ADDR_W-1:0] q_addr1,
  input  logic [REG_ADDR_W-1:0] q_addr2,
  output logic                  q_hit1,
  output logic                  q_hit2
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_req_t                     head;
  logic                        full, empty, push, pop;
  logic [DEPTH*REG_ADDR_W-1:0] pend_addrs;
  wb_sel_e                     sel;

  logic [SW-1:0]         starve_q, starve_d;
  logic                  a_stall_q, a_stall_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]     reg_din_q, reg_din_d;

  assign b_ready = rst_n && !full;
  assign push    = b_valid && b_ready && (b_addr != '0);
  assign pop     = (sel == SEL_B);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_req   ({b_addr, b_data}),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (b_count),
    .pend_addrs (pend_addrs)
  );

  always_comb begin
    sel = SEL_NONE;
    if (a_stall_q) begin
      if (!empty) sel = SEL_B;
    end else if (a_valid && (a_addr != '0)) begin
      sel = SEL_A;
    end else if (!empty) begin
      sel = SEL_B;
    end
  end

  // A beating a waiting B head ages it; a forced drain follows the limit
  always_comb begin
    starve_d  = starve_q;
    a_stall_d = 1'b0;
    if (pop || empty) begin
      starve_d = '0;
    end else if (sel == SEL_A) begin
      starve_d  = starve_q + 1'b1;
      a_stall_d = (starve_q == SW'(STARVE_LIMIT - 1));
    end
  end

  always_comb begin
    reg_write_d = (sel != SEL_NONE);
    reg_addr_d  = reg_addr_q;
    reg_din_d   = reg_din_q;
    unique case (sel)
      SEL_A: begin
        reg_addr_d = a_addr;
        reg_din_d  = a_data;
      end
      SEL_B: begin
        reg_addr_d = head.addr;
        reg_din_d  = head.data;
      end
      default: ;
    endcase
  end

  always_comb begin
    q_hit1 = reg_write_q && addr_match(q_addr1, reg_addr_q);
    q_hit2 = reg_write_q && addr_match(q_addr2, reg_addr_q);
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_match(q_addr1, pend_addrs[i*REG_ADDR_W +: REG_ADDR_W]))
        q_hit1 = 1'b1;
      if (addr_match(q_addr2, pend_addrs[i*REG_ADDR_W +: REG_ADDR_W]))
        q_hit2 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q    <= '0;
      a_stall_q   <= 1'b0;
      reg_write_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_din_q   <= '0;
    end else begin
      starve_q    <= starve_d;
      a_stall_q   <= a_stall_d;
      reg_write_q <= reg_write_d;
      reg_addr_q  <= reg_addr_d;
      reg_din_q   <= reg_din_d;
    end
  end

  assign a_stall   = a_stall_q;
  assign reg_write = reg_write_q;
  assign reg_addr  = reg_addr_q;
  assign reg_din   = reg_din_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter.
// Reference model predicts writes, occupancy, stalls and hits.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIM   = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid;
  logic [4:0]    a_addr;
  logic [31:0]   a_data;
  logic          a_stall;
  logic          b_valid;
  logic          b_ready;
  logic [4:0]    b_addr;
  logic [31:0]   b_data;
  logic [CW-1:0] b_count;
  logic          reg_write;
  logic [4:0]    reg_addr;
  logic [31:0]   reg_din;
  logic [4:0]    q_addr1, q_addr2;
  logic          q_hit1, q_hit2;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .a_stall(a_stall),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_addr(b_addr), .b_data(b_data), .b_count(b_count),
    .reg_write(reg_write), .reg_addr(reg_addr), .reg_din(reg_din),
    .q_addr1(q_addr1), .q_addr2(q_addr2),
    .q_hit1(q_hit1), .q_hit2(q_hit2)
  );

  always #5 clk = ~clk;

  int      n_vec = 0;
  int      n_bad = 0;
  wb_req_t mq[$];
  wb_req_t sb[$];
  logic    m_stall = 1'b0;
  int      m_starve = 0;
  logic    m_we = 1'b0;
  logic [4:0] m_addr = '0;
  int      seen_stall;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_hit(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (m_we && m_addr == a) return 1'b1;
    foreach (mq[i]) if (mq[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_stall  = 1'b0;
    m_starve = 0;
    m_we     = 1'b0;
    m_addr   = '0;
  endtask

  task automatic model_step();
    int      n;
    int      sel;
    logic    hs, nst;
    wb_req_t r;
    if (!rst_n) begin
      model_reset();
      return;
    end
    n   = mq.size();
    hs  = b_valid && (n < DEPTH);
    sel = 0;
    if (m_stall) sel = (n > 0) ? 2 : 0;
    else if (a_valid && a_addr != 5'd0) sel = 1;
    else if (n > 0) sel = 2;
    nst = 1'b0;
    if (sel == 2 || n == 0) m_starve = 0;
    else if (sel == 1) begin
      m_starve++;
      if (m_starve == LIM) nst = 1'b1;
    end
    m_we = (sel != 0);
    if (sel == 1) begin
      r = '{addr: a_addr, data: a_data};
      sb.push_back(r);
      m_addr = a_addr;
    end else if (sel == 2) begin
      r = mq.pop_front();
      sb.push_back(r);
      m_addr = r.addr;
    end
    if (hs && b_addr != 5'd0) mq.push_back('{addr: b_addr, data: b_data});
    m_stall = nst;
  endtask

  task automatic cycle();
    wb_req_t e;
    @(negedge clk);
    chk("b_ready", b_ready, rst_n && (mq.size() < DEPTH));
    chk("q_hit1", q_hit1, m_hit(q_addr1));
    chk("q_hit2", q_hit2, m_hit(q_addr2));
    @(posedge clk);
    model_step();
    #1;
    chk("reg_write", reg_write, m_we);
    chk("a_stall", a_stall, m_stall);
    chk("b_count", b_count, mq.size());
    if (a_stall) seen_stall++;
    if (reg_write === 1'b1) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wr_addr", reg_addr, e.addr);
        chk("wr_data", reg_din, e.data);
      end
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa,
                       input logic [31:0] ad, input logic bv,
                       input logic [4:0] ba, input logic [31:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    q_addr1 = '0;
    q_addr2 = '0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_we", reg_write, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_din", reg_din, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_cnt", b_count, 0);
    chk("rst_ready", b_ready, 0);
    cycle();
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // A write then idle
    drive(1, 5'd5, 32'h1234, 0, 0, 0);
    cycle();
    chk("a_lat_we", reg_write, 1);
    chk("a_lat_addr", reg_addr, 5);
    chk("a_lat_din", reg_din, 32'h1234);
    idle(1);
    chk("a_idle_we", reg_write, 0);

    // Single B push
    drive(0, 0, 0, 1, 5'd7, 32'hAA);
    cycle();
    chk("b_t1_cnt", b_count, 1);
    chk("b_t1_we", reg_write, 0);
    idle(1);
    chk("b_t2_we", reg_write, 1);
    chk("b_t2_addr", reg_addr, 7);
    chk("b_t2_cnt", b_count, 0);
    idle(1);

    // A held busy, fill FIFO, force a starvation drain
    seen_stall = 0;
    q_addr2 = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (i < 4)
        drive(1, 5'(10 + i), 32'(i), 1, 5'(20 + i), 32'(100 + i));
      else if (i < 6)
        drive(1, 5'(10 + i), 32'(i), 1, 5'd24, 32'hDEAD);
      else
        drive(1, 5'(10 + i), 32'(i), 0, 0, 0);
      cycle();
      if (i == 4) chk("full_cnt", b_count, 4);
      if (i == 5) chk("full_ready", b_ready, 0);
    end
    chk("stall_once", seen_stall, 1);
    idle(6);

    // Pending lookup on x3 while A busy
    q_addr1 = 5'd3;
    drive(1, 5'd9, 32'h9, 1, 5'd3, 32'h333);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(11 + i), 32'(i), 0, 0, 0);
      cycle();
      chk("hit_x3", q_hit1, 1);
    end
    idle(4);
    chk("hit_x3_gone", q_hit1, 0);
    q_addr1 = '0;

    // Address zero on both ports
    drive(1, 5'd0, 32'hFFFF, 1, 5'd0, 32'hEEEE);
    @(negedge clk);
    chk("x0_ready", b_ready, 1);
    cycle();
    chk("x0_we", reg_write, 0);
    chk("x0_cnt", b_count, 0);
    idle(1);

    // Async reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(1 + i), 32'(i), 1, 5'(25 + i), 32'(i));
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", b_count, 0);
    chk("arst_we", reg_write, 0);
    chk("arst_stall", a_stall, 0);
    chk("arst_ready", b_ready, 0);
    model_reset();
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      q_addr1 = 5'($urandom_range(0, 31));
      q_addr2 = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)),
            $urandom, ($urandom_range(0, 9) < 5),
            5'($urandom_range(0, 31)), $urandom);
      cycle();
    end
    idle(12);
    chk("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
